// File: rtl/lmdpl_table_gen_if.sv
// ============================================================================
// Module   : lmdpl_table_gen_if
// Brief    : Request/table bundle between a controller and lmdpl_table_gen.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface lmdpl_table_gen_if;
  logic       start;
  logic [1:0] op;
  logic [2:0] rnd;
  logic [7:0] t;
  logic       m_q;
  logic       eval;
  logic       busy;
  logic       done;
  logic       alarm;

  modport master (
    output start, op, rnd,
    input  t, m_q, eval, busy, done, alarm
  );

  modport slave (
    input  start, op, rnd,
    output t, m_q, eval, busy, done, alarm
  );
endinterface

`default_nettype wire

// File: rtl/lmdpl_table_gen.sv
// ============================================================================
// Module   : lmdpl_table_gen
// Brief    : Precharge/evaluate LMDPL gate-table generator; optional dual-rail
//            integrity checker enabled by macro LMDPL_ALARM_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lmdpl_table_gen #(
  parameter int PRE_CYC  = 2,
  parameter int EVAL_CYC = 2
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  lmdpl_table_gen_if.slave  bus
);

  localparam logic [3:0] c_pre_load  = 4'(PRE_CYC - 1);
  localparam logic [3:0] c_eval_load = 4'(EVAL_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [1:0] r_op;
  logic [2:0] r_mask;
  logic [7:0] r_t;
  logic       r_eval;
  logic       r_busy;
  logic       r_done;
  logic       r_alarm;

  logic [7:0] w_table;
  logic [1:0] w_xy;
  logic       w_bit;

  function automatic logic gate_fn(input logic [1:0] f_op, input logic a, input logic b);
    logic f;
    case (f_op)
      2'b00:   f = a & b;
      2'b01:   f = a | b;
      2'b10:   f = a ^ b;
      default: f = ~(a & b);
    endcase
    return f;
  endfunction

  // Row idx = x + 2y holds f(a,b)^m_q on the true rail and its complement below.
  always_comb begin
    w_table = 8'h00;
    w_xy    = 2'b00;
    w_bit   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_xy           = 2'(i);
      w_bit          = gate_fn(r_op, w_xy[0] ^ r_mask[0], w_xy[1] ^ r_mask[1]) ^ r_mask[2];
      w_table[4 + i] = w_bit;
      w_table[i]     = ~w_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_op    <= 2'b00;
      r_mask  <= 3'b000;
      r_t     <= 8'h00;
      r_eval  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_PRE;
            r_op    <= bus.op;
            r_mask  <= bus.rnd;
            r_cnt   <= c_pre_load;
            r_busy  <= 1'b1;
          end
        end
        S_PRE: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_EVAL;
            r_cnt   <= c_eval_load;
            r_t     <= w_table;
            r_eval  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_EVAL: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_DONE;
            r_cnt   <= 4'd0;
            r_t     <= 8'h00;
            r_eval  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LMDPL_ALARM_EN
  // Watches the driven table itself so any disturbance on the output is caught.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alarm <= 1'b0;
    end else if (r_eval ? ((bus.t[7:4] ^ bus.t[3:0]) != 4'hF) : (bus.t != 8'h00)) begin
      r_alarm <= 1'b1;
    end
  end
`else
  assign r_alarm = 1'b0;
`endif

  assign bus.t     = r_t;
  assign bus.m_q   = r_mask[2];
  assign bus.eval  = r_eval;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.alarm = r_alarm;

endmodule

`default_nettype wire

// File: tb/tb_lmdpl_table_gen.sv
// ============================================================================
// Module   : tb_lmdpl_table_gen
// Brief    : Directed-vector bench for lmdpl_table_gen (PRE_CYC=2, EVAL_CYC=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lmdpl_table_gen;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lmdpl_table_gen_if bus ();

  lmdpl_table_gen #(.PRE_CYC(2), .EVAL_CYC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called one step after an edge while IDLE; returns in the first PRE cycle.
  task automatic issue(input logic [1:0] o, input logic [2:0] r);
    bus.start = 1'b1;
    bus.op    = o;
    bus.rnd   = r;
    tick();
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.rnd   = 3'b000;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.rnd   = 3'b000;
    #3;
    n_vec++;
    if ({bus.t, bus.m_q, bus.eval, bus.busy, bus.done, bus.alarm} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got t=%h m_q=%b eval=%b busy=%b done=%b alarm=%b, want all 0",
               bus.t, bus.m_q, bus.eval, bus.busy, bus.done, bus.alarm);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_basic_and;
    issue(2'b00, 3'b000);
    for (int c = 1; c <= 2; c++) begin
      n_vec++;
      if (bus.t !== 8'h00 || bus.busy !== 1'b1 || bus.eval !== 1'b0) begin
        n_err++;
        $display("FAIL and_pre%0d: t=%h busy=%b eval=%b, want t=00 busy=1 eval=0", c, bus.t, bus.busy, bus.eval);
      end
      tick();
    end
    for (int c = 3; c <= 4; c++) begin
      n_vec++;
      if (bus.t !== 8'h87 || bus.eval !== 1'b1 || bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL and_eval%0d: t=%h eval=%b done=%b, want t=87 eval=1 done=0", c, bus.t, bus.eval, bus.done);
      end
      tick();
    end
    n_vec++;
    if (bus.done !== 1'b1 || bus.t !== 8'h00 || bus.eval !== 1'b0) begin
      n_err++;
      $display("FAIL and_done: done=%b t=%h eval=%b, want done=1 t=00 eval=0", bus.done, bus.t, bus.eval);
    end
    tick();
    n_vec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.alarm !== 1'b0) begin
      n_err++;
      $display("FAIL and_idle: done=%b busy=%b alarm=%b, want 0 0 0", bus.done, bus.busy, bus.alarm);
    end
  endtask

  task automatic test_ops;
    logic [1:0] ops  [4] = '{2'b01, 2'b11, 2'b01, 2'b11};
    logic [2:0] rnds [4] = '{3'b000, 3'b000, 3'b010, 3'b110};
    logic [7:0] exps [4] = '{8'hE1, 8'h78, 8'hB4, 8'h2D};
    for (int v = 0; v < 4; v++) begin
      issue(ops[v], rnds[v]);
      tick();
      tick();
      for (int c = 0; c < 2; c++) begin
        n_vec++;
        if (bus.t !== exps[v]) begin
          n_err++;
          $display("FAIL op%0d_eval: op=%b rnd=%b t=%h want %h", v, ops[v], rnds[v], bus.t, exps[v]);
        end
        tick();
      end
      n_vec++;
      if (bus.done !== 1'b1 || bus.t !== 8'h00) begin
        n_err++;
        $display("FAIL op%0d_done: done=%b t=%h want 1 00", v, bus.done, bus.t);
      end
      tick();
    end
  endtask

  task automatic test_mask_and_ignore;
    issue(2'b00, 3'b101);
    n_vec++;
    if (bus.m_q !== 1'b1) begin
      n_err++;
      $display("FAIL mq_capture: m_q=%b want 1", bus.m_q);
    end
    tick();
    tick();
    n_vec++;
    if (bus.t !== 8'hB4) begin
      n_err++;
      $display("FAIL masked_eval: t=%h want b4", bus.t);
    end
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.rnd   = 3'b000;
    tick();
    bus.start = 1'b0;
    bus.op    = 2'b00;
    n_vec++;
    if (bus.t !== 8'hB4 || bus.m_q !== 1'b1) begin
      n_err++;
      $display("FAIL ignore_start: t=%h m_q=%b want b4 1", bus.t, bus.m_q);
    end
    tick();
    n_vec++;
    if (bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL ignore_done: done=%b want 1", bus.done);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_vec++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.m_q !== 1'b1) begin
        n_err++;
        $display("FAIL ignore_after%0d: done=%b busy=%b m_q=%b want 0 0 1", c, bus.done, bus.busy, bus.m_q);
      end
    end
  endtask

  task automatic test_back_to_back;
    issue(2'b10, 3'b000);
    tick();
    tick();
    n_vec++;
    if (bus.t !== 8'h69) begin
      n_err++;
      $display("FAIL xor_eval: t=%h want 69", bus.t);
    end
    tick();
    tick();
    n_vec++;
    if (bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first_done: done=%b want 1", bus.done);
    end
    tick();
    issue(2'b00, 3'b000);
    for (int c = 1; c <= 5; c++) begin
      n_vec++;
      if (bus.busy !== 1'b1 || bus.done !== (c == 5)) begin
        n_err++;
        $display("FAIL b2b_cycle%0d: busy=%b done=%b want busy=1 done=%b", c, bus.busy, bus.done, c == 5);
      end
      if (c == 3 || c == 4) begin
        n_vec++;
        if (bus.t !== 8'h87) begin
          n_err++;
          $display("FAIL b2b_eval%0d: t=%h want 87", c, bus.t);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_op;
    issue(2'b00, 3'b000);
    tick();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.t !== 8'h00 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_pre: t=%h busy=%b want 00 0", bus.t, bus.busy);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_vec++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL rst_pre_after%0d: done=%b busy=%b want 0 0", c, bus.done, bus.busy);
      end
    end
    issue(2'b10, 3'b000);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.t !== 8'h00 || bus.eval !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_eval: t=%h eval=%b busy=%b want 00 0 0", bus.t, bus.eval, bus.busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_vec++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_eval_nodone: done=%b want 0", bus.done);
    end
  endtask

`ifdef LMDPL_ALARM_EN
  task automatic test_alarm;
    issue(2'b00, 3'b000);
    tick();
    tick();
    // t[4] joins t[0] high, so the rails no longer complement each other.
    force bus.t = 8'h97;
    tick();
    release bus.t;
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (bus.alarm !== 1'b1) begin
        n_err++;
        $display("FAIL alarm_held%0d: alarm=%b want 1", c, bus.alarm);
      end
      tick();
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.alarm !== 1'b0) begin
      n_err++;
      $display("FAIL alarm_clear: alarm=%b want 0", bus.alarm);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_and();
    test_ops();
    test_mask_and_ignore();
    test_back_to_back();
    test_reset_mid_op();
`ifdef LMDPL_ALARM_EN
    test_alarm();
`else
    n_vec++;
    if (bus.alarm !== 1'b0) begin
      n_err++;
      $display("FAIL alarm_tied: alarm=%b want 0", bus.alarm);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
